common_wrap_counter: RTL and testbench
======================================

COMMON_WRAP_COUNTER -- requirements
Module: common_wrap_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 5, counter width in bits (legal 2..16).
REQ-002 SHALL have parameter LIMIT, default 2**WIDTH-1, terminal count; legal range 1..2**WIDTH-1.
REQ-003 SHALL have parameter SATURATE, default 0; 0 = wrap mode, 1 = saturate mode.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port clear, input, 1, synchronous return to zero.
REQ-007 SHALL have port load, input, 1, load load_value.
REQ-008 SHALL have port load_value, input, WIDTH, value to load.
REQ-009 SHALL have port incr, input, 1, increment request.
REQ-010 SHALL have port decr, input, 1, decrement request.
REQ-011 SHALL have port q, output, WIDTH, registered count.
REQ-012 SHALL have port c, output, 1, registered one-cycle carry pulse (wrap or saturation hit on increment).
REQ-013 SHALL have port b, output, 1, registered one-cycle borrow pulse (wrap or saturation hit on decrement).
REQ-014 SHALL have port at_limit, output, 1, combinational q == LIMIT.
REQ-015 SHALL have port at_zero, output, 1, combinational q == 0.

Function
REQ-016 SHALL update q, c and b one cycle after the qualifying input; no combinational path from inputs to q, c or b.
REQ-017 SHALL apply priority clear > load > (incr and decr) > incr > decr.
REQ-018 SHALL, on clear, set q=0, c=0, b=0.
REQ-019 SHALL, on load, set q=load_value if load_value<=LIMIT, else q=LIMIT; c=0, b=0.
REQ-020 SHALL, with incr and decr both high, hold q and set c=0, b=0.
REQ-021 SHALL, on incr with q<LIMIT, set q=q+1, c=0.
REQ-022 SHALL, on incr with q==LIMIT, set q=0 (SATURATE=0) or hold q=LIMIT (SATURATE=1); c=1 in both modes.
REQ-023 SHALL, on decr with q>0, set q=q-1, b=0.
REQ-024 SHALL, on decr with q==0, set q=LIMIT (SATURATE=0) or hold q=0 (SATURATE=1); b=1 in both modes.
REQ-025 SHALL, with no request active, hold q and drive c=0, b=0.
REQ-026 SHALL never hold q>LIMIT in any reachable state.
REQ-027 SHALL compute q+1 and q-1 in WIDTH+1 bits; the MSB is the raw carry/borrow, used only when LIMIT == 2**WIDTH-1.

Reset
REQ-028 SHALL, when reset is high at a rising edge, set q=0, c=0, b=0 regardless of all other inputs.
REQ-029 SHALL, when reset is asserted mid-sequence, discard any pending request in that cycle; the first request after reset deasserts acts on q=0.

Structure
REQ-030 SHALL hold the mode constants (WRAP=0, SAT=1) in the shared common definitions header, not locally.
REQ-031 SHALL instantiate one combinational sub-module common_incr_w (parameter WIDTH; ports d, q, c), the parametrised generalisation of the 5-bit incrementer, for the +1 path.
REQ-032 SHALL implement the -1 path, limit compare and state register in common_wrap_counter itself.

Verification
REQ-033 SHALL cover wrap: WIDTH=5, LIMIT=31, SATURATE=0; 32 incr pulses from 0 -> q steps 1..31 then 0; c=1 exactly in the cycle q becomes 0.
REQ-034 SHALL cover non-power-of-2 limit: WIDTH=4, LIMIT=9; decr at q=0 -> q=9, b=1 one cycle; incr at q=9 -> q=0, c=1.
REQ-035 SHALL cover saturation: SATURATE=1, LIMIT=31, q=31; 3 incr pulses -> q stays 31, c=1 each of the 3 cycles; decr at q=0 -> q=0, b=1.
REQ-036 SHALL cover priority: clear, load=1 (load_value=7) and incr all high at q=5 -> q=0; then load=1 (load_value=7) with incr=1 -> q=7, c=0.
REQ-037 SHALL cover clamp and simultaneous requests: LIMIT=9, load_value=14 -> q=9; then incr=decr=1 -> q=9, c=b=0.
REQ-038 SHALL cover reset: reset=1 with incr=1 at q=12 -> q=0, c=0 next cycle; with reset=0 and incr=1 in the following cycle -> q=1.

Source files
------------

// File: rtl/common_wrap_counter_pkg.sv
// Shared definitions for the wrap/saturate counter: mode constants,
// request encoding and the priority decoder used by the top level.
package common_wrap_counter_pkg;

    // Behaviour when the count runs off either end of its range.
    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // The single action the counter takes in a given cycle.
    typedef enum logic [2:0] {
        OP_HOLD,
        OP_CLEAR,
        OP_LOAD,
        OP_BOTH,
        OP_INCR,
        OP_DECR
    } op_e;

    // Collapse the request lines into one action:
    // clear > load > (incr and decr) > incr > decr.
    function automatic op_e decode_op(
        input logic clear,
        input logic load,
        input logic incr,
        input logic decr
    );
        op_e op;
        op = OP_HOLD;
        if (clear) begin
            op = OP_CLEAR;
        end else if (load) begin
            op = OP_LOAD;
        end else if (incr && decr) begin
            op = OP_BOTH;
        end else if (incr) begin
            op = OP_INCR;
        end else if (decr) begin
            op = OP_DECR;
        end
        return op;
    endfunction

endpackage

// File: rtl/common_incr_w.sv
// Parametrised combinational incrementer: q = d + 1, c = carry out of
// the top bit (set only when d is all ones).
module common_incr_w #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             c
);

    // Add in WIDTH+1 bits so the carry falls out as the extra MSB.
    assign {c, q} = {1'b0, d} + {{WIDTH{1'b0}}, 1'b1};

endmodule

// File: rtl/common_wrap_counter.sv
// Up/down counter over 0..LIMIT with clear and clamped load. At either end
// it wraps or saturates depending on SATURATE, and reports the event as a
// registered one-cycle carry (top end) or borrow (bottom end) pulse.
module common_wrap_counter
    import common_wrap_counter_pkg::*;
#(
    parameter int WIDTH    = 5,
    parameter int LIMIT    = 2**WIDTH - 1,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             incr,
    input  logic             decr,
    output logic [WIDTH-1:0] q,
    output logic             c,
    output logic             b,
    output logic             at_limit,
    output logic             at_zero
);

    localparam logic [WIDTH-1:0] LIMIT_V    = WIDTH'(LIMIT);
    // When the limit is the full binary range the raw carry/borrow bits
    // already say "at the end"; otherwise an explicit compare is needed.
    localparam bit               FULL_RANGE = (LIMIT == (2**WIDTH) - 1);
    localparam bit               SAT_MODE   = (SATURATE == MODE_SAT);

    logic [WIDTH-1:0] inc_q;
    logic             inc_c;
    logic [WIDTH-1:0] dec_q;
    logic             dec_b;
    logic             hit_top;
    logic             hit_bot;
    logic [WIDTH-1:0] load_clamped;
    op_e              op;
    logic [WIDTH-1:0] q_next;
    logic             c_next;
    logic             b_next;

    common_incr_w #(
        .WIDTH (WIDTH)
    ) u_incr (
        .d (q),
        .q (inc_q),
        .c (inc_c)
    );

    // -1 path in WIDTH+1 bits; the MSB is the raw borrow.
    assign {dec_b, dec_q} = {1'b0, q} - {{WIDTH{1'b0}}, 1'b1};

    // End-of-range detection and load clamp.
    always_comb begin
        hit_top      = FULL_RANGE ? inc_c : (q == LIMIT_V);
        hit_bot      = FULL_RANGE ? dec_b : (q == '0);
        load_clamped = (load_value > LIMIT_V) ? LIMIT_V : load_value;
        op           = decode_op(clear, load, incr, decr);
    end

    // Next count and carry/borrow pulses for the selected action.
    always_comb begin
        q_next = q;
        c_next = 1'b0;
        b_next = 1'b0;
        case (op)
            OP_CLEAR: q_next = '0;
            OP_LOAD:  q_next = load_clamped;
            OP_BOTH:  q_next = q;
            OP_INCR: begin
                if (hit_top) begin
                    c_next = 1'b1;
                    q_next = SAT_MODE ? LIMIT_V : '0;
                end else begin
                    q_next = inc_q;
                end
            end
            OP_DECR: begin
                if (hit_bot) begin
                    b_next = 1'b1;
                    q_next = SAT_MODE ? '0 : LIMIT_V;
                end else begin
                    q_next = dec_q;
                end
            end
            default:  q_next = q;
        endcase
    end

    // State register; reset overrides every request in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
            c <= 1'b0;
            b <= 1'b0;
        end else begin
            q <= q_next;
            c <= c_next;
            b <= b_next;
        end
    end

    // Combinational status flags straight off the registered count.
    always_comb begin
        at_limit = (q == LIMIT_V);
        at_zero  = (q == '0);
    end

endmodule

// File: tb/tb_common_wrap_counter.sv
// Bench for common_wrap_counter: three instances (5-bit wrap, 4-bit limit 9
// wrap, 5-bit saturate) share one stimulus stream; a behavioural model
// pushes expected {q,c,b} per instance and the values are popped after
// each clock edge.
module tb_common_wrap_counter;

    logic       clk;
    logic       reset;
    logic       clear;
    logic       load;
    logic [4:0] lv;
    logic       incr;
    logic       decr;

    logic [4:0] q_w;
    logic       c_w, b_w, al_w, az_w;
    logic [3:0] q_l;
    logic       c_l, b_l, al_l, az_l;
    logic [4:0] q_s;
    logic       c_s, b_s, al_s, az_s;

    common_wrap_counter #(.WIDTH(5), .LIMIT(31), .SATURATE(0)) u_wrap (
        .clk(clk), .reset(reset), .clear(clear), .load(load),
        .load_value(lv), .incr(incr), .decr(decr),
        .q(q_w), .c(c_w), .b(b_w), .at_limit(al_w), .at_zero(az_w)
    );

    common_wrap_counter #(.WIDTH(4), .LIMIT(9), .SATURATE(0)) u_lim (
        .clk(clk), .reset(reset), .clear(clear), .load(load),
        .load_value(lv[3:0]), .incr(incr), .decr(decr),
        .q(q_l), .c(c_l), .b(b_l), .at_limit(al_l), .at_zero(az_l)
    );

    common_wrap_counter #(.WIDTH(5), .LIMIT(31), .SATURATE(1)) u_sat (
        .clk(clk), .reset(reset), .clear(clear), .load(load),
        .load_value(lv), .incr(incr), .decr(decr),
        .q(q_s), .c(c_s), .b(b_s), .at_limit(al_s), .at_zero(az_s)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model / scoreboard state ----------------
    int    n_total = 0;
    int    n_bad   = 0;
    int    cfg_w[3]   = '{5, 4, 5};
    int    cfg_lim[3] = '{31, 9, 31};
    int    cfg_sat[3] = '{0, 0, 1};
    string cfg_nm[3]  = '{"wrap", "lim9", "sat"};
    int    m_q[3]     = '{0, 0, 0};
    logic [6:0] exp_q[$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance the reference model for one instance and return {q,c,b}.
    task automatic model_step(input int k, output logic [6:0] e);
        int lvm, lim, nq;
        logic ec, eb;
        lim = cfg_lim[k];
        lvm = int'(lv) & ((1 << cfg_w[k]) - 1);
        nq  = m_q[k];
        ec  = 1'b0;
        eb  = 1'b0;
        if (reset || clear) begin
            nq = 0;
        end else if (load) begin
            nq = (lvm > lim) ? lim : lvm;
        end else if (incr && decr) begin
            nq = m_q[k];
        end else if (incr) begin
            if (m_q[k] == lim) begin
                ec = 1'b1;
                nq = (cfg_sat[k] == 1) ? lim : 0;
            end else begin
                nq = m_q[k] + 1;
            end
        end else if (decr) begin
            if (m_q[k] == 0) begin
                eb = 1'b1;
                nq = (cfg_sat[k] == 1) ? 0 : lim;
            end else begin
                nq = m_q[k] - 1;
            end
        end
        m_q[k] = nq;
        e = {nq[4:0], ec, eb};
    endtask

    function automatic logic [8:0] get_obs(input int k);
        logic [8:0] o;
        case (k)
            0:       o = {q_w, c_w, b_w, al_w, az_w};
            1:       o = {1'b0, q_l, c_l, b_l, al_l, az_l};
            default: o = {q_s, c_s, b_s, al_s, az_s};
        endcase
        return o;
    endfunction

    // ---------------- driver ----------------
    // Apply one cycle of stimulus, push expectations, clock, then compare.
    task automatic drive(input logic r, input logic cl, input logic ld,
                         input logic [4:0] v, input logic in, input logic de);
        logic [6:0] e;
        logic [8:0] o;
        reset = r; clear = cl; load = ld; lv = v; incr = in; decr = de;
        for (int k = 0; k < 3; k++) begin
            model_step(k, e);
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            e = exp_q.pop_front();
            o = get_obs(k);
            check_val({cfg_nm[k], "_q"}, 32'(o[8:4]), 32'(e[6:2]));
            check_val({cfg_nm[k], "_c"}, 32'(o[3]), 32'(e[1]));
            check_val({cfg_nm[k], "_b"}, 32'(o[2]), 32'(e[0]));
            check_val({cfg_nm[k], "_at_limit"}, 32'(o[1]), 32'(m_q[k] == cfg_lim[k]));
            check_val({cfg_nm[k], "_at_zero"}, 32'(o[0]), 32'(m_q[k] == 0));
        end
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1; clear = 1'b0; load = 1'b0; lv = '0; incr = 1'b0; decr = 1'b0;

        // Reset state.
        drive(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        check_val("rst_q", 32'(q_w), 32'd0);
        check_val("rst_at_zero", 32'(az_w), 32'd1);

        // 32 increments from zero: full wrap on the 5-bit counter.
        for (int i = 0; i < 32; i++) drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        check_val("wrap_end_q", 32'(q_w), 32'd0);
        check_val("wrap_end_c", 32'(c_w), 32'd1);
        idle();
        check_val("wrap_c_pulse", 32'(c_w), 32'd0);

        // Saturation: hold at 31 with carry every cycle; borrow at zero.
        drive(1'b0, 1'b0, 1'b1, 5'd31, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
            check_val("sat_hold_q", 32'(q_s), 32'd31);
            check_val("sat_hold_c", 32'(c_s), 32'd1);
        end
        drive(1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        check_val("sat_floor_q", 32'(q_s), 32'd0);
        check_val("sat_floor_b", 32'(b_s), 32'd1);
        check_val("lim9_under_q", 32'(q_l), 32'd9);
        check_val("lim9_under_b", 32'(b_l), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        check_val("lim9_over_q", 32'(q_l), 32'd0);
        check_val("lim9_over_c", 32'(c_l), 32'd1);

        // Priority: clear beats load and incr; load beats incr.
        drive(1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0);
        check_val("prio_clear_q", 32'(q_w), 32'd0);
        drive(1'b0, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0);
        check_val("prio_load_q", 32'(q_w), 32'd7);
        check_val("prio_load_c", 32'(c_w), 32'd0);

        // Clamp and simultaneous incr/decr.
        drive(1'b0, 1'b0, 1'b1, 5'd14, 1'b0, 1'b0);
        check_val("clamp_q", 32'(q_l), 32'd9);
        drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
        check_val("both_q", 32'(q_l), 32'd9);
        check_val("both_cb", 32'({c_l, b_l}), 32'd0);

        // Reset discards a pending increment; the next one acts on zero.
        drive(1'b0, 1'b0, 1'b1, 5'd12, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        check_val("rst_mid_q", 32'(q_w), 32'd0);
        check_val("rst_mid_c", 32'(c_w), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        check_val("rst_after_q", 32'(q_w), 32'd1);

        // Random mix of all requests.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 59) == 0,
                  $urandom_range(0, 29) == 0,
                  $urandom_range(0, 7) == 0,
                  5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
